adc_scan_filter: RTL and testbench



---
 rtl/adc_scan_filter.sv | 210 +++++++++++++++++++++
 tb/tb_adc_scan_filter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_filter.sv
// -----------------------------------------------------------------------------
// adc_scan_filter
//   Channel sequencer and decimating average filter placed behind the MCP3008
//   SPI reader. Steps round-robin through the enabled channels. On each channel
//   it throws away SETTLE samples, then averages 2^AVG_LOG2 samples. It emits
//   one tagged average per channel, together with an over-threshold flag.
//
// Parameters
//   CH_MASK   enabled channels, bit n = channel n (0 keeps the block idle)
//   AVG_LOG2  log2 of samples per averaging window (0..6)
//   SETTLE    samples discarded after every channel change (0..15)
//   THRESH    over-threshold compare level
//
// Ports
//   clk_50M       system clock, rising edge
//   rst           asynchronous active-low reset
//   enable        level, high = scanning
//   sample_valid  one-cycle strobe for a new conversion on sample_data
//   sample_data   10-bit raw ADC result
//   channel       channel select driven to the SPI reader
//   avg_valid     one-cycle strobe, new average on avg_data
//   avg_data      truncated window average (held between strobes)
//   avg_channel   channel that avg_data belongs to (held)
//   over_thresh   avg_data >= THRESH (held)
//   scan_done     one-cycle strobe when the highest enabled channel is emitted
// -----------------------------------------------------------------------------
module adc_scan_filter #(
  parameter logic [7:0]  CH_MASK  = 8'hFF,
  parameter int unsigned AVG_LOG2 = 3,
  parameter int unsigned SETTLE   = 1,
  parameter logic [9:0]  THRESH   = 10'd768
) (
  input  logic       clk_50M,
  input  logic       rst,
  input  logic       enable,
  input  logic       sample_valid,
  input  logic [9:0] sample_data,
  output logic [2:0] channel,
  output logic       avg_valid,
  output logic [9:0] avg_data,
  output logic [2:0] avg_channel,
  output logic       over_thresh,
  output logic       scan_done
);

  typedef enum logic [1:0] {IDLE, DISCARD, ACCUM, EMIT} state_t;

  // Lowest set bit of the mask, 0 when the mask is empty.
  function automatic logic [2:0] lowest_enabled(input logic [7:0] mask);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) begin
        res = 3'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Highest set bit of the mask, 0 when the mask is empty.
  function automatic logic [2:0] highest_enabled(input logic [7:0] mask);
    logic [2:0] res;
    res = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        res = 3'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Next enabled channel after cur, wrapping 7 -> 0. The search ends on cur
  // itself, so a single enabled channel maps onto itself.
  function automatic logic [2:0] next_enabled(input logic [7:0] mask, input logic [2:0] cur);
    logic [2:0] res;
    logic [2:0] idx;
    logic       found;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = cur + 3'(i);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return res;
  endfunction

  localparam int unsigned      ACC_W      = 10 + AVG_LOG2;
  localparam int unsigned      CNT_W      = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] WIN_LEN    = CNT_W'(1 << AVG_LOG2);
  localparam logic [3:0]       SETTLE_LEN = 4'(SETTLE);
  localparam logic [2:0]       FIRST_CH   = lowest_enabled(CH_MASK);
  localparam logic [2:0]       LAST_CH    = highest_enabled(CH_MASK);
  localparam logic             MASK_EMPTY = (CH_MASK == 8'h00);
  // State entered after every channel selection.
  localparam state_t           START_ST   = (SETTLE_LEN == 4'd0) ? ACCUM : DISCARD;

  state_t           state_r;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] smp_cnt_r;
  logic [3:0]       disc_cnt_r;

  logic [ACC_W-1:0] acc_sum_s;
  logic [9:0]       avg_s;
  logic [CNT_W-1:0] smp_cnt_nxt_s;
  logic [3:0]       disc_cnt_nxt_s;
  logic [2:0]       next_ch_s;

  // Datapath: running sum including the current sample and its truncated average.
  always_comb begin
    acc_sum_s      = acc_r + ACC_W'(sample_data);
    // The window sum always fits in ACC_W bits, so the top 10 bits are the average.
    avg_s          = acc_sum_s[ACC_W-1:AVG_LOG2];
    smp_cnt_nxt_s  = smp_cnt_r + CNT_W'(1);
    disc_cnt_nxt_s = disc_cnt_r + 4'd1;
    next_ch_s      = next_enabled(CH_MASK, channel);
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_50M or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      acc_r       <= '0;
      smp_cnt_r   <= '0;
      disc_cnt_r  <= 4'd0;
      channel     <= 3'd0;
      avg_valid   <= 1'b0;
      avg_data    <= 10'd0;
      avg_channel <= 3'd0;
      over_thresh <= 1'b0;
      scan_done   <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      scan_done <= 1'b0;
      case (state_r)
        IDLE: begin
          acc_r      <= '0;
          smp_cnt_r  <= '0;
          disc_cnt_r <= 4'd0;
          if (enable && !MASK_EMPTY) begin
            channel <= FIRST_CH;
            state_r <= START_ST;
          end else begin
            state_r <= IDLE;
          end
        end
        DISCARD: begin
          if (!enable) begin
            disc_cnt_r <= 4'd0;
            state_r    <= IDLE;
          end else if (sample_valid) begin
            if (disc_cnt_nxt_s == SETTLE_LEN) begin
              disc_cnt_r <= 4'd0;
              state_r    <= ACCUM;
            end else begin
              disc_cnt_r <= disc_cnt_nxt_s;
            end
          end else begin
            state_r <= DISCARD;
          end
        end
        ACCUM: begin
          if (!enable) begin
            // Disabling abandons the partial window, even on its last sample.
            acc_r     <= '0;
            smp_cnt_r <= '0;
            state_r   <= IDLE;
          end else if (sample_valid) begin
            if (smp_cnt_nxt_s == WIN_LEN) begin
              avg_valid   <= 1'b1;
              avg_data    <= avg_s;
              avg_channel <= channel;
              over_thresh <= (avg_s >= THRESH);
              scan_done   <= (channel == LAST_CH);
              channel     <= next_ch_s;
              acc_r       <= '0;
              smp_cnt_r   <= '0;
              state_r     <= EMIT;
            end else begin
              acc_r     <= acc_sum_s;
              smp_cnt_r <= smp_cnt_nxt_s;
            end
          end else begin
            state_r <= ACCUM;
          end
        end
        EMIT: begin
          // Strobes are high this cycle; any sample_valid here is dropped.
          if (!enable) begin
            state_r <= IDLE;
          end else begin
            state_r <= START_ST;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_filter.sv
// -----------------------------------------------------------------------------
// tb_adc_scan_filter
//   Bench for adc_scan_filter with three instances:
//     u_a : CH_MASK=8'h05, AVG_LOG2=3, SETTLE=1  (main windows, aborts, reset)
//     u_z : CH_MASK=8'h00                        (must never emit)
//     u_b : CH_MASK=8'h82, AVG_LOG2=0, SETTLE=0  (per-sample emit, 7 -> 1 wrap)
// -----------------------------------------------------------------------------
module tb_adc_scan_filter;

  typedef struct {
    logic [9:0] start;  // first sample of the window
    logic [9:0] step;   // increment between window samples
    logic [2:0] ch;     // channel expected while the window runs
    logic [9:0] avg;    // expected avg_data
    logic       over;   // expected over_thresh
    logic       scan;   // expected scan_done
    logic [2:0] nxt;    // expected channel after the emit edge
  } win_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_a, sv_a, en_z, en_b, sv_b;
  logic [9:0] data_a, data_b;

  logic [2:0] a_channel, a_avg_channel, z_channel, z_avg_channel, b_channel, b_avg_channel;
  logic       a_avg_valid, a_over, a_scan, z_avg_valid, z_over, z_scan, b_avg_valid, b_over, b_scan;
  logic [9:0] a_avg_data, z_avg_data, b_avg_data;

  int n_total = 0;
  int n_pass  = 0;
  int a_pulses = 0;
  int z_pulses = 0;
  int b_pulses = 0;

  always #5 clk = ~clk;

  adc_scan_filter #(.CH_MASK(8'h05), .AVG_LOG2(3), .SETTLE(1), .THRESH(10'd768)) u_a (
    .clk_50M(clk), .rst(rst), .enable(en_a), .sample_valid(sv_a), .sample_data(data_a),
    .channel(a_channel), .avg_valid(a_avg_valid), .avg_data(a_avg_data),
    .avg_channel(a_avg_channel), .over_thresh(a_over), .scan_done(a_scan)
  );

  adc_scan_filter #(.CH_MASK(8'h00), .AVG_LOG2(3), .SETTLE(1), .THRESH(10'd768)) u_z (
    .clk_50M(clk), .rst(rst), .enable(en_z), .sample_valid(sv_a), .sample_data(data_a),
    .channel(z_channel), .avg_valid(z_avg_valid), .avg_data(z_avg_data),
    .avg_channel(z_avg_channel), .over_thresh(z_over), .scan_done(z_scan)
  );

  adc_scan_filter #(.CH_MASK(8'h82), .AVG_LOG2(0), .SETTLE(0), .THRESH(10'd768)) u_b (
    .clk_50M(clk), .rst(rst), .enable(en_b), .sample_valid(sv_b), .sample_data(data_b),
    .channel(b_channel), .avg_valid(b_avg_valid), .avg_data(b_avg_data),
    .avg_channel(b_avg_channel), .over_thresh(b_over), .scan_done(b_scan)
  );

  // Count avg_valid pulses of every instance, sampled away from the active edge.
  always @(negedge clk) begin
    if (a_avg_valid) a_pulses <= a_pulses + 1;
    if (z_avg_valid) z_pulses <= z_pulses + 1;
    if (b_avg_valid) b_pulses <= b_pulses + 1;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One-cycle sample strobe on u_a/u_z; returns on the negedge after the accept edge.
  task automatic send_a(input logic [9:0] d);
    @(negedge clk);
    sv_a   = 1'b1;
    data_a = d;
    @(negedge clk);
    sv_a   = 1'b0;
  endtask

  task automatic send_b(input logic [9:0] d);
    @(negedge clk);
    sv_b   = 1'b1;
    data_b = d;
    @(negedge clk);
    sv_b   = 1'b0;
  endtask

  // One full u_a window: a discarded 999 then eight samples, checked at the emit cycle.
  task automatic run_window(input win_t w);
    int p0;
    check("win_chan_pre", a_channel, w.ch);
    p0 = a_pulses;
    send_a(10'd999);
    for (int k = 0; k < 8; k++) send_a(w.start + 10'(k * w.step));
    #1;
    check("win_valid", a_avg_valid, 1);
    check("win_avg_data", a_avg_data, w.avg);
    check("win_avg_channel", a_avg_channel, w.ch);
    check("win_over", a_over, w.over);
    check("win_scan", a_scan, w.scan);
    check("win_chan_next", a_channel, w.nxt);
    check("win_pulse_count", a_pulses - p0, 1);
  endtask

  win_t tbl[7];
  win_t w;
  int   p0;

  initial begin
    //        start    step    ch     avg       over  scan  nxt
    tbl[0] = '{10'd100, 10'd0, 3'd0, 10'd100,  1'b0, 1'b0, 3'd2};
    tbl[1] = '{10'd800, 10'd0, 3'd2, 10'd800,  1'b1, 1'b1, 3'd0};
    tbl[2] = '{10'd0,   10'd1, 3'd0, 10'd3,    1'b0, 1'b0, 3'd2};  // 28/8 truncates
    tbl[3] = '{10'd1023,10'd0, 3'd2, 10'd1023, 1'b1, 1'b1, 3'd0};  // sum 8184, no wrap
    tbl[4] = '{10'd767, 10'd0, 3'd0, 10'd767,  1'b0, 1'b0, 3'd2};  // just below THRESH
    tbl[5] = '{10'd768, 10'd0, 3'd2, 10'd768,  1'b1, 1'b1, 3'd0};  // exactly THRESH
    tbl[6] = '{10'd760, 10'd2, 3'd0, 10'd767,  1'b0, 1'b0, 3'd2};  // 6136/8 = 767

    rst = 1'b0; en_a = 1'b0; en_z = 1'b0; en_b = 1'b0;
    sv_a = 1'b0; sv_b = 1'b0; data_a = 10'd0; data_b = 10'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_channel", a_channel, 0);
    check("rst_avg_valid", a_avg_valid, 0);
    check("rst_avg_data", a_avg_data, 0);
    check("rst_avg_channel", a_avg_channel, 0);
    check("rst_over", a_over, 0);
    check("rst_scan", a_scan, 0);
    @(negedge clk);
    rst = 1'b1;

    // Main windows on u_a; u_z is enabled alongside and must stay silent.
    @(negedge clk);
    en_a = 1'b1;
    en_z = 1'b1;
    @(negedge clk);
    #1;
    check("enable_first_chan", a_channel, 0);
    for (int i = 0; i < 7; i++) run_window(tbl[i]);

    // Abort after 5 of 8 samples on channel 2: outputs hold, nothing emitted.
    p0 = a_pulses;
    send_a(10'd999);
    for (int k = 0; k < 5; k++) send_a(10'd1000);
    en_a = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("abort_no_pulse", a_pulses - p0, 0);
    check("abort_chan_hold", a_channel, 2);
    check("abort_data_hold", a_avg_data, 767);
    check("abort_avgch_hold", a_avg_channel, 0);
    @(negedge clk);
    en_a = 1'b1;
    @(negedge clk);
    #1;
    check("reenable_chan", a_channel, 0);
    w = '{10'd50, 10'd0, 3'd0, 10'd50, 1'b0, 1'b0, 3'd2};
    run_window(w);

    // Disable in the same cycle as the final sample: window abandoned.
    p0 = a_pulses;
    send_a(10'd999);
    for (int k = 0; k < 7; k++) send_a(10'd10);
    @(negedge clk);
    sv_a   = 1'b1;
    data_a = 10'd10;
    en_a   = 1'b0;
    @(negedge clk);
    sv_a = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("lastsample_abort_no_pulse", a_pulses - p0, 0);
    check("lastsample_abort_data_hold", a_avg_data, 50);
    @(negedge clk);
    en_a = 1'b1;
    @(negedge clk);
    #1;
    check("lastsample_reenable_chan", a_channel, 0);
    w = '{10'd900, 10'd0, 3'd0, 10'd900, 1'b1, 1'b0, 3'd2};
    run_window(w);

    // Asynchronous reset mid-window on channel 2.
    send_a(10'd999);
    for (int k = 0; k < 4; k++) send_a(10'd1000);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_channel", a_channel, 0);
    check("midrst_avg_data", a_avg_data, 0);
    check("midrst_over", a_over, 0);
    check("midrst_avg_valid", a_avg_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    w = '{10'd200, 10'd0, 3'd0, 10'd200, 1'b0, 1'b0, 3'd2};
    run_window(w);

    // u_b: every sample emits; a strobe during EMIT is dropped; 7 wraps to 1.
    en_a = 1'b0;
    @(negedge clk);
    en_b = 1'b1;
    @(negedge clk);
    #1;
    check("b_first_chan", b_channel, 1);
    p0 = b_pulses;
    send_b(10'd300);
    #1;
    check("b1_valid", b_avg_valid, 1);
    check("b1_data", b_avg_data, 300);
    check("b1_avgch", b_avg_channel, 1);
    check("b1_scan", b_scan, 0);
    check("b1_chan_next", b_channel, 7);
    @(negedge clk);
    sv_b   = 1'b1;
    data_b = 10'd900;
    @(negedge clk);
    data_b = 10'd5;  // strobe stays high through the EMIT cycle
    #1;
    check("b2_valid", b_avg_valid, 1);
    check("b2_data", b_avg_data, 900);
    check("b2_avgch", b_avg_channel, 7);
    check("b2_over", b_over, 1);
    check("b2_scan", b_scan, 1);
    check("b2_chan_wrap", b_channel, 1);
    @(negedge clk);
    sv_b = 1'b0;
    #1;
    check("b_emit_drop_valid", b_avg_valid, 0);
    check("b_emit_drop_data", b_avg_data, 900);
    check("b_emit_drop_chan", b_channel, 1);
    send_b(10'd400);
    #1;
    check("b3_data", b_avg_data, 400);
    check("b3_avgch", b_avg_channel, 1);
    check("b_pulse_count", b_pulses - p0, 3);

    // u_z has been enabled for the whole run with CH_MASK = 0.
    check("z_no_pulse", z_pulses, 0);
    check("z_channel", z_channel, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
